regbank_debug_ctrl: RTL and testbench

- Debug controller for the single-cycle CPU's 16x16-bit register bank.
- Halts the CPU and muxes the bank's write port and read port 1 between the CPU and a debug host.
- Streams a full register dump out over a valid/ready interface.
- Sits in the CPU top, between the datapath (write-back and read port 1) and the register bank.

---
 rtl/cpu_dbg_pkg.sv | 21 ++
 rtl/dbg_dump_stream.sv | 97 +++++++++
 rtl/regbank_debug_ctrl.sv | 166 ++++++++++++++++
 tb/tb_regbank_debug_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the register-bank debug controller.
// Holds the controller state encoding and the default data/address widths,
// which must match the 16x16-bit register bank of the CPU.
package cpu_dbg_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int NREGS_DEF  = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_DUMP   = 2'd2
    } dbg_state_e;

    // The CPU is frozen in every state other than RUN.
    function automatic logic is_stalled(input dbg_state_e st);
        return (st != ST_RUN);
    endfunction

endpackage

// File: rtl/dbg_dump_stream.sv
// Register dump streamer.
// Walks the dump index 0..NREGS-1, presenting it as the bank read address,
// and captures each read word into a valid/ready output holding register.
// Ports:
//   clk, reset       clock and asynchronous active-high reset
//   start            restart the dump at index 0 (entry into DUMP)
//   active           controller is in DUMP; loads are allowed
//   rd_data          bank read port 1 data for rd_addr
//   rd_addr          current dump index, drives bank read port 1 in DUMP
//   out_valid/ready  output handshake
//   out_data/idx     dumped word and its register index
//   dump_done        one-cycle pulse after the last word is accepted
//   last_hs          combinational: last word is being accepted this cycle
module dbg_dump_stream
    import cpu_dbg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREGS  = NREGS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              active,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              dump_done,
    output logic              last_hs
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    logic [ADDR_W-1:0] idx_r;
    logic              all_loaded_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic [ADDR_W-1:0] out_idx_r;
    logic              dump_done_r;
    logic              load_s;
    logic              last_hs_s;

    // Load when the holding register is empty or being drained this cycle;
    // all_loaded_r stops the index at NREGS-1 instead of wrapping.
    always_comb begin
        load_s    = 1'b0;
        last_hs_s = 1'b0;
        if (active) begin
            load_s    = !all_loaded_r && (!out_valid_r || out_ready);
            last_hs_s = all_loaded_r && out_valid_r && out_ready;
        end else begin
            load_s    = 1'b0;
            last_hs_s = 1'b0;
        end
    end

    // Dump index, holding register and completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_r        <= '0;
            all_loaded_r <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_idx_r    <= '0;
            dump_done_r  <= 1'b0;
        end else begin
            dump_done_r <= last_hs_s;
            if (start) begin
                idx_r        <= '0;
                all_loaded_r <= 1'b0;
                out_valid_r  <= 1'b0;
            end else if (load_s) begin
                out_data_r  <= rd_data;
                out_idx_r   <= idx_r;
                out_valid_r <= 1'b1;
                if (idx_r == LAST_IDX) begin
                    all_loaded_r <= 1'b1;
                end else begin
                    idx_r <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end else if (last_hs_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign rd_addr   = idx_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;
    assign dump_done = dump_done_r;
    assign last_hs   = last_hs_s;

endmodule

// File: rtl/regbank_debug_ctrl.sv
// Debug controller for the CPU's register bank.
// Halts the CPU, hands the bank write port to a debug host while halted,
// and streams a full register dump through a valid/ready interface.
// Ports:
//   clk, reset                   clock and asynchronous active-high reset
//   dbg_halt_req/dbg_resume      halt and release requests
//   dump_start                   start a register dump (while halted)
//   host_we/wa/wd                debug host write port
//   cpu_we/wa/wd, cpu_ra1        CPU write-back and read port 1 address
//   rf_rd1                       bank read port 1 data
//   rf_we/wa/wd, rf_ra1          muxed bank write port and read address
//   cpu_stall, halted            registered CPU freeze / halted status
//   out_valid/ready/data/idx     dump stream
//   dump_done                    pulse after the last dump word is accepted
module regbank_debug_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREGS  = NREGS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dbg_halt_req,
    input  logic              dbg_resume,
    input  logic              dump_start,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_wa,
    input  logic [DATA_W-1:0] host_wd,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_wa,
    input  logic [DATA_W-1:0] cpu_wd,
    input  logic [ADDR_W-1:0] cpu_ra1,
    input  logic [DATA_W-1:0] rf_rd1,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic [ADDR_W-1:0] rf_ra1,
    output logic              cpu_stall,
    output logic              halted,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              dump_done
);

    dbg_state_e        state_r;
    dbg_state_e        state_nxt_s;
    logic              cpu_stall_r;
    logic              halted_r;
    logic              start_s;
    logic              active_s;
    logic              last_hs_s;
    logic [ADDR_W-1:0] dump_addr_s;

    assign start_s  = (state_r == ST_HALTED) && dump_start;
    assign active_s = (state_r == ST_DUMP);

    dbg_dump_stream #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_dump (
        .clk       (clk),
        .reset     (reset),
        .start     (start_s),
        .active    (active_s),
        .rd_data   (rf_rd1),
        .rd_addr   (dump_addr_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .dump_done (dump_done),
        .last_hs   (last_hs_s)
    );

    // Next-state logic; dump_start wins over dbg_resume, and resume is
    // not remembered while a dump is running.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (dbg_halt_req) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (dump_start) begin
                    state_nxt_s = ST_DUMP;
                end else if (dbg_resume) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALTED;
                end
            end
            ST_DUMP: begin
                if (last_hs_s) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    state_nxt_s = ST_DUMP;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Bank port muxes: CPU in RUN, host while halted, dump walker in DUMP.
    // The CPU write sampled in the halting cycle still goes through because
    // the mux follows the current state, not the next one.
    always_comb begin
        rf_we  = cpu_we;
        rf_wa  = cpu_wa;
        rf_wd  = cpu_wd;
        rf_ra1 = cpu_ra1;
        case (state_r)
            ST_RUN: begin
                rf_we  = cpu_we;
                rf_wa  = cpu_wa;
                rf_wd  = cpu_wd;
                rf_ra1 = cpu_ra1;
            end
            ST_HALTED: begin
                rf_we  = host_we;
                rf_wa  = host_wa;
                rf_wd  = host_wd;
                rf_ra1 = cpu_ra1;
            end
            ST_DUMP: begin
                rf_we  = 1'b0;
                rf_wa  = host_wa;
                rf_wd  = host_wd;
                rf_ra1 = dump_addr_s;
            end
            default: begin
                rf_we  = 1'b0;
                rf_wa  = cpu_wa;
                rf_wd  = cpu_wd;
                rf_ra1 = cpu_ra1;
            end
        endcase
    end

    // State register with registered stall/halted status taken from the
    // next state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_RUN;
            cpu_stall_r <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cpu_stall_r <= is_stalled(state_nxt_s);
            halted_r    <= is_stalled(state_nxt_s);
        end
    end

    assign cpu_stall = cpu_stall_r;
    assign halted    = halted_r;

endmodule

// File: tb/tb_regbank_debug_ctrl.sv
// Self-checking bench for regbank_debug_ctrl with a behavioural register bank.
module tb_regbank_debug_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        dbg_halt_req, dbg_resume, dump_start;
    logic        host_we;
    logic [3:0]  host_wa;
    logic [15:0] host_wd;
    logic        cpu_we;
    logic [3:0]  cpu_wa;
    logic [15:0] cpu_wd;
    logic [3:0]  cpu_ra1;
    logic [15:0] rf_rd1;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [15:0] rf_wd;
    logic [3:0]  rf_ra1;
    logic        cpu_stall, halted, out_valid, out_ready, dump_done;
    logic [15:0] out_data;
    logic [3:0]  out_idx;

    logic [15:0] bank [16];

    regbank_debug_ctrl dut (
        .clk(clk), .reset(reset), .dbg_halt_req(dbg_halt_req), .dbg_resume(dbg_resume),
        .dump_start(dump_start), .host_we(host_we), .host_wa(host_wa), .host_wd(host_wd),
        .cpu_we(cpu_we), .cpu_wa(cpu_wa), .cpu_wd(cpu_wd), .cpu_ra1(cpu_ra1),
        .rf_rd1(rf_rd1), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_ra1(rf_ra1),
        .cpu_stall(cpu_stall), .halted(halted), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    // Register bank: synchronous write, combinational read port 1.
    always @(posedge clk) begin
        if (rf_we) bank[rf_wa] <= rf_wd;
    end
    assign rf_rd1 = bank[rf_ra1];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 = running, 1 = halted, 2 = dumping
    int          m_mode;
    bit          m_first;   // first dump cycle, nothing shown yet
    int          m_acc;     // words accepted so far in this dump
    bit          m_done;
    logic [15:0] ref_bank [16];

    int          hs_n, done_n, valid_n;
    logic [3:0]  hs_idx [64];
    logic [15:0] hs_data [64];
    logic        snap_we;
    logic [3:0]  snap_wa;
    logic [15:0] snap_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_first = 1'b0; m_acc = 0; m_done = 1'b0;
    endtask

    // Mid-cycle: bank port routing for the current mode, and handshake logging.
    task automatic check_comb();
        snap_we = rf_we; snap_wa = rf_wa; snap_wd = rf_wd;
        if (m_mode == 0) begin
            chk("run_we", 32'(rf_we), 32'(cpu_we));
            chk("run_wa", 32'(rf_wa), 32'(cpu_wa));
            chk("run_wd", 32'(rf_wd), 32'(cpu_wd));
            chk("run_ra1", 32'(rf_ra1), 32'(cpu_ra1));
        end else if (m_mode == 1) begin
            chk("halt_we", 32'(rf_we), 32'(host_we));
            chk("halt_wa", 32'(rf_wa), 32'(host_wa));
            chk("halt_wd", 32'(rf_wd), 32'(host_wd));
        end else begin
            chk("dump_we", 32'(rf_we), 32'd0);
        end
        if (out_valid === 1'b1) valid_n++;
        if (out_valid === 1'b1 && out_ready && hs_n < 64) begin
            hs_idx[hs_n]  = out_idx;
            hs_data[hs_n] = out_data;
            hs_n++;
        end
    endtask

    // Clock edge as seen by the rules: the write goes where the current mode sends it.
    task automatic model_edge();
        m_done = 1'b0;
        case (m_mode)
            0: begin
                if (cpu_we) ref_bank[cpu_wa] = cpu_wd;
                if (dbg_halt_req) m_mode = 1;
            end
            1: begin
                if (host_we) ref_bank[host_wa] = host_wd;
                if (dump_start) begin
                    m_mode = 2; m_first = 1'b1; m_acc = 0;
                end else if (dbg_resume) begin
                    m_mode = 0;
                end
            end
            default: begin
                if (m_first) begin
                    m_first = 1'b0;
                end else if (out_ready) begin
                    m_acc++;
                    if (m_acc == 16) begin
                        m_mode = 1; m_done = 1'b1;
                    end
                end
            end
        endcase
    endtask

    task automatic check_regs();
        bit exp_valid;
        exp_valid = (m_mode == 2) && !m_first;
        chk("cpu_stall", 32'(cpu_stall), 32'(m_mode != 0));
        chk("halted", 32'(halted), 32'(m_mode != 0));
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("dump_done", 32'(dump_done), 32'(m_done));
        if (dump_done === 1'b1) done_n++;
        if (exp_valid) begin
            chk("out_idx", 32'(out_idx), 32'(m_acc));
            chk("out_data", 32'(out_data), 32'(ref_bank[m_acc]));
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_comb();
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic idle_inputs();
        dbg_halt_req = 1'b0; dbg_resume = 1'b0; dump_start = 1'b0;
        host_we = 1'b0; host_wa = 4'd0; host_wd = 16'd0;
        cpu_we = 1'b0; cpu_wa = 4'd0; cpu_wd = 16'd0; cpu_ra1 = 4'd0;
    endtask

    task automatic clear_logs();
        hs_n = 0; done_n = 0; valid_n = 0;
    endtask

    // Runs a started dump. mode 0: ready always high, 1: ready 1,0,0,1 pattern.
    // resume_cycles: hold dbg_resume high for that many dump cycles.
    task automatic run_dump(input int mode, input int resume_cycles, output int steps);
        bit seen;
        seen = 1'b0; steps = 0;
        while (!seen && steps < 80) begin
            if (mode == 0) out_ready = 1'b1;
            else out_ready = ((steps % 4) == 0 || (steps % 4) == 3);
            dbg_resume = (steps < resume_cycles);
            step();
            steps++;
            if (dump_done === 1'b1) seen = 1'b1;
        end
        dbg_resume = 1'b0;
        chk("dump_timeout", 32'(seen), 32'd1);
    endtask

    initial begin
        int steps;
        idle_inputs();
        out_ready = 1'b0;
        model_reset();
        clear_logs();
        reset = 1'b1;
        #12;
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_done", 32'(dump_done), 32'd0);
        #10 reset = 1'b0;

        // Fill the bank through the CPU path.
        for (int i = 0; i < 16; i++) begin
            cpu_we = 1'b1; cpu_wa = 4'(i); cpu_wd = 16'hA000 + 16'(i * 17); cpu_ra1 = 4'(15 - i);
            step();
        end

        // CPU write R3 = 7 in RUN.
        cpu_we = 1'b1; cpu_wa = 4'd3; cpu_wd = 16'h0007; cpu_ra1 = 4'd3;
        step();
        chk("t1_we", 32'(snap_we), 32'd1);
        chk("t1_wa", 32'(snap_wa), 32'd3);
        chk("t1_wd", 32'(snap_wd), 32'h7);
        chk("t1_stall", 32'(cpu_stall), 32'd0);

        // Halt while the CPU writes R4 = 5; the next CPU write is masked.
        cpu_wa = 4'd4; cpu_wd = 16'h0005; dbg_halt_req = 1'b1;
        step();
        chk("t2_stall", 32'(cpu_stall), 32'd1);
        chk("t2_r4", 32'(bank[4]), 32'h5);
        dbg_halt_req = 1'b0; cpu_wd = 16'h0009;
        step();
        chk("t2_masked_we", 32'(snap_we), 32'd0);
        chk("t2_r4_kept", 32'(bank[4]), 32'h5);
        cpu_we = 1'b0; dbg_halt_req = 1'b1;   // halt request while halted
        step();
        dbg_halt_req = 1'b0;

        // Host write R2 = BEEF together with dump_start, ready held high.
        clear_logs();
        host_we = 1'b1; host_wa = 4'd2; host_wd = 16'hBEEF; dump_start = 1'b1; out_ready = 1'b1;
        step();
        host_we = 1'b0; dump_start = 1'b0;
        run_dump(0, 0, steps);
        chk("t3_cycles", 32'(steps), 32'd17);
        chk("t3_words", 32'(hs_n), 32'd16);
        chk("t3_valid_cycles", 32'(valid_n), 32'd16);
        chk("t3_word2", 32'(hs_data[2]), 32'hBEEF);
        chk("t3_word4", 32'(hs_data[4]), 32'h5);
        for (int k = 0; k < 16; k++) chk("t3_idx_seq", 32'(hs_idx[k]), 32'(k));
        out_ready = 1'b0;
        step();
        chk("t3_done_once", 32'(done_n), 32'd1);
        chk("t3_halted", 32'(halted), 32'd1);

        // Dump with ready toggling 1,0,0,1.
        clear_logs();
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        run_dump(1, 0, steps);
        chk("t4_words", 32'(hs_n), 32'd16);
        for (int k = 0; k < 16; k++) chk("t4_idx_seq", 32'(hs_idx[k]), 32'(k));
        chk("t4_done_once", 32'(done_n), 32'd1);

        // dump_start and dbg_resume together: dump wins, resume ignored in DUMP.
        clear_logs();
        dump_start = 1'b1; dbg_resume = 1'b1;
        step();
        dump_start = 1'b0;
        run_dump(0, 3, steps);
        chk("t6_words", 32'(hs_n), 32'd16);
        out_ready = 1'b0;
        step();
        chk("t6_still_halted", 32'(halted), 32'd1);
        dbg_resume = 1'b1;
        step();
        dbg_resume = 1'b0;
        chk("t6_resumed", 32'(cpu_stall), 32'd0);

        // Reset during a dump, at word 7.
        dbg_halt_req = 1'b1;
        step();
        dbg_halt_req = 1'b0;
        clear_logs();
        dump_start = 1'b1; out_ready = 1'b1;
        step();
        dump_start = 1'b0;
        for (int k = 0; k < 20 && hs_n < 7; k++) step();
        chk("t5_reached_w7", 32'(out_idx), 32'd7);
        idle_inputs();
        reset = 1'b1;
        #2;
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_stall", 32'(cpu_stall), 32'd0);
        chk("t5_halted", 32'(halted), 32'd0);
        chk("t5_idx", 32'(out_idx), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step();
        cpu_we = 1'b1; cpu_wa = 4'd5; cpu_wd = 16'h1234; cpu_ra1 = 4'd5;
        step();
        chk("t5_run_we", 32'(snap_we), 32'd1);
        chk("t5_run_r5", 32'(bank[5]), 32'h1234);
        chk("t5_run_stall", 32'(cpu_stall), 32'd0);
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
